// File: rtl/fp_arb_pkg.sv
// Shared types and constants for the fp unit arbiter.
// No logic: state encoding and the quiet-NaN result used on watchdog expiry.
// No handshake of its own.
package fp_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_st_e;

    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

endpackage

// File: rtl/fp_unit_arbiter_rr_pick.sv
// Round-robin picker: first set request after ptr, wrapping modulo N_REQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is taken.
module rr_pick #(
    parameter int N_REQ = 4,
    localparam int PW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt_onehot,
    output logic [PW-1:0]    gnt_idx,
    output logic             any
);

    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        // Walk the order backwards so the earliest candidate is the last written.
        for (int i = N_REQ; i >= 1; i--) begin
            int idx;
            idx = (int'(ptr) + i) % N_REQ;
            if (req[idx[PW-1:0]]) begin
                gnt_idx = idx[PW-1:0];
                any     = 1'b1;
            end
        end
        gnt_onehot = any ? (N_REQ'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/fp_unit_arbiter.sv
// Round-robin sequencer sharing one fp unit among N_REQ requesters; optional watchdog under FP_ARB_WDOG_EN.
// Latency: grant one edge after req_valid&unit_ready; rsp_finish one edge after unit_finish.
// Backpressure: no grant while unit_ready is low or an operation is in flight; requests simply wait.
module fp_unit_arbiter
    import fp_arb_pkg::*;
#(
    parameter int DBL_WIDTH = 64,
    parameter int N_REQ     = 4,
    parameter int WDOG_CYC  = 1024,
    localparam int PW = $clog2(N_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DBL_WIDTH-1:0] req_a,
    input  logic [N_REQ*DBL_WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]           req_ready,
    output logic [N_REQ-1:0]           rsp_finish,
    output logic [DBL_WIDTH-1:0]       rsp_result,
    output logic                       busy,
    output logic                       err_timeout,
    output logic                       unit_valid,
    input  logic                       unit_ready,
    input  logic                       unit_finish,
    output logic [DBL_WIDTH-1:0]       unit_a,
    output logic [DBL_WIDTH-1:0]       unit_b,
    input  logic [DBL_WIDTH-1:0]       unit_result
);

    arb_st_e              state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [PW-1:0]        owner_q, owner_d;
    logic [DBL_WIDTH-1:0] unit_a_q, unit_a_d;
    logic [DBL_WIDTH-1:0] unit_b_q, unit_b_d;
    logic                 unit_valid_q, unit_valid_d;
    logic [N_REQ-1:0]     req_ready_q, req_ready_d;
    logic [N_REQ-1:0]     rsp_finish_q, rsp_finish_d;
    logic [DBL_WIDTH-1:0] rsp_result_q, rsp_result_d;

    logic [N_REQ-1:0]     pick_onehot;
    logic [PW-1:0]        pick_idx;
    logic                 pick_any;

`ifdef FP_ARB_WDOG_EN
    localparam int WW = $clog2(WDOG_CYC);
    logic [WW-1:0]        wdog_cnt_q, wdog_cnt_d;
    logic                 err_timeout_q, err_timeout_d;
`endif

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req        (req_valid),
        .ptr        (ptr_q),
        .gnt_onehot (pick_onehot),
        .gnt_idx    (pick_idx),
        .any        (pick_any)
    );

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        owner_d      = owner_q;
        unit_a_d     = unit_a_q;
        unit_b_d     = unit_b_q;
        unit_valid_d = 1'b0;
        req_ready_d  = '0;
        rsp_finish_d = '0;
        rsp_result_d = rsp_result_q;
`ifdef FP_ARB_WDOG_EN
        wdog_cnt_d    = wdog_cnt_q;
        err_timeout_d = 1'b0;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (pick_any && unit_ready) begin
                    unit_a_d     = req_a[pick_idx*DBL_WIDTH +: DBL_WIDTH];
                    unit_b_d     = req_b[pick_idx*DBL_WIDTH +: DBL_WIDTH];
                    owner_d      = pick_idx;
                    req_ready_d  = pick_onehot;
                    unit_valid_d = 1'b1;
                    state_d      = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                state_d = ARB_WAIT;
`ifdef FP_ARB_WDOG_EN
                wdog_cnt_d = '0;
`endif
            end
            ARB_WAIT: begin
                // A real finish beats a watchdog expiry landing on the same cycle.
                if (unit_finish) begin
                    rsp_result_d = unit_result;
                    rsp_finish_d = N_REQ'(1) << owner_q;
                    ptr_d        = owner_q;
                    state_d      = ARB_IDLE;
                end
`ifdef FP_ARB_WDOG_EN
                else if (wdog_cnt_q == WW'(WDOG_CYC - 1)) begin
                    rsp_result_d  = DBL_WIDTH'(QNAN);
                    rsp_finish_d  = N_REQ'(1) << owner_q;
                    err_timeout_d = 1'b1;
                    ptr_d         = owner_q;
                    state_d       = ARB_IDLE;
                end else begin
                    wdog_cnt_d = wdog_cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            ptr_q        <= PW'(N_REQ - 1);
            owner_q      <= '0;
            unit_a_q     <= '0;
            unit_b_q     <= '0;
            unit_valid_q <= 1'b0;
            req_ready_q  <= '0;
            rsp_finish_q <= '0;
            rsp_result_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            owner_q      <= owner_d;
            unit_a_q     <= unit_a_d;
            unit_b_q     <= unit_b_d;
            unit_valid_q <= unit_valid_d;
            req_ready_q  <= req_ready_d;
            rsp_finish_q <= rsp_finish_d;
            rsp_result_q <= rsp_result_d;
        end
    end

`ifdef FP_ARB_WDOG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt_q    <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            wdog_cnt_q    <= wdog_cnt_d;
            err_timeout_q <= err_timeout_d;
        end
    end
    assign err_timeout = err_timeout_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign req_ready  = req_ready_q;
    assign rsp_finish = rsp_finish_q;
    assign rsp_result = rsp_result_q;
    assign busy       = (state_q != ARB_IDLE);
    assign unit_valid = unit_valid_q;
    assign unit_a     = unit_a_q;
    assign unit_b     = unit_b_q;

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Directed bench for fp_unit_arbiter with a behavioural fp adder of configurable latency.
module tb_fp_unit_arbiter;

    localparam int W = 64;
    localparam int N = 4;
    localparam logic [63:0] ONE  = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] TWO  = 64'h4000_0000_0000_0000;
    localparam logic [63:0] HALF = 64'h3FE0_0000_0000_0000;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a, req_b;
    logic [N-1:0]   req_ready, rsp_finish;
    logic [W-1:0]   rsp_result, unit_a, unit_b, unit_result;
    logic           busy, err_timeout, unit_valid, unit_ready, unit_finish;

    always #5 clk = ~clk;

    fp_unit_arbiter #(.DBL_WIDTH(W), .N_REQ(N), .WDOG_CYC(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .rsp_finish  (rsp_finish),
        .rsp_result  (rsp_result),
        .busy        (busy),
        .err_timeout (err_timeout),
        .unit_valid  (unit_valid),
        .unit_ready  (unit_ready),
        .unit_finish (unit_finish),
        .unit_a      (unit_a),
        .unit_b      (unit_b),
        .unit_result (unit_result)
    );

    // Adder model: result appears lat cycles after unit_valid is sampled.
    int          cnt = 0;
    int          lat = 5;
    logic [63:0] res_m = '0;
    bit          ready_en = 1'b1;
    bit          spur = 1'b0;
    bit          model_clear = 1'b0;

    always @(posedge clk) begin
        if (model_clear) cnt <= 0;
        else if (unit_valid) begin
            cnt   <= lat;
            res_m <= $realtobits($bitstoreal(unit_a) + $bitstoreal(unit_b));
        end else if (cnt != 0) cnt <= cnt - 1;
    end

    assign unit_finish = (cnt == 1) || spur;
    assign unit_ready  = (cnt == 0) && ready_en;
    assign unit_result = res_m;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready(output int id);
        id = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                for (int j = 0; j < N; j++) if (req_ready[j]) id = j;
                break;
            end
        end
        if (id < 0) begin
            checks++; errors++;
            $display("FAIL wait_ready: no req_ready within 60 cycles");
        end
    endtask

    task automatic wait_finish(output logic [N-1:0] f, output logic [63:0] r);
        f = '0; r = '0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (rsp_finish != '0) begin
                f = rsp_finish; r = rsp_result;
                break;
            end
        end
        if (f == '0) begin
            checks++; errors++;
            $display("FAIL wait_finish: no rsp_finish within 60 cycles");
        end
    endtask

    task automatic wait_unit_finish();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (unit_finish) begin seen = 1'b1; break; end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL wait_unit_finish: no unit_finish within 60 cycles");
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        int          id;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
    } vec_t;

    vec_t        tv [5];
    int          id;
    int          n;
    logic [N-1:0] f;
    logic [63:0] r;
    bit          seen_bad;

    initial begin
        tv[0] = '{0, ONE,  ONE,  64'h4000_0000_0000_0000};
        tv[1] = '{1, ONE,  TWO,  64'h4008_0000_0000_0000};
        tv[2] = '{2, TWO,  TWO,  64'h4010_0000_0000_0000};
        tv[3] = '{3, ONE,  HALF, 64'h3FF8_0000_0000_0000};
        tv[4] = '{0, HALF, HALF, 64'h3FF0_0000_0000_0000};

        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 0);
        chk("rst_rsp_finish", 64'(rsp_finish), 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_unit_valid_busy_err", {unit_valid, busy, err_timeout}, 0);
        chk("rst_unit_ab", unit_a | unit_b, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single request from requester 2: 1.0 + 2.0.
        req_a[2*W +: W] = ONE; req_b[2*W +: W] = TWO; req_valid = 4'b0100;
        @(negedge clk);
        chk("t1_unit_valid", 64'(unit_valid), 1);
        chk("t1_req_ready", 64'(req_ready), 64'h4);
        chk("t1_unit_a", unit_a, ONE);
        chk("t1_unit_b", unit_b, TWO);
        req_valid = '0;
        @(negedge clk);
        chk("t1_unit_valid_one_cycle", {unit_valid, req_ready}, 0);
        chk("t1_busy", 64'(busy), 1);
        wait_unit_finish();
        @(negedge clk);
        chk("t1_rsp_finish", 64'(rsp_finish), 64'h4);
        chk("t1_rsp_result", rsp_result, 64'h4008_0000_0000_0000);
        @(negedge clk);
        chk("t1_rsp_finish_pulse", 64'(rsp_finish), 0);
        chk("t1_result_held", rsp_result, 64'h4008_0000_0000_0000);

        // All four at once after reset, then 0 re-requests as it finishes.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_a[tv[i].id*W +: W] = tv[i].a;
            req_b[tv[i].id*W +: W] = tv[i].b;
        end
        req_valid = 4'hF;
        for (int i = 0; i < 5; i++) begin
            wait_ready(id);
            chk("t2_grant_order", 64'(id), 64'(tv[i].id));
            chk("t2_unit_a", unit_a, tv[i].a);
            chk("t2_unit_b", unit_b, tv[i].b);
            if (id >= 0) req_valid[id] = 1'b0;
            wait_finish(f, r);
            chk("t2_finish_bit", 64'(f), 64'(1) << tv[i].id);
            chk("t2_result", r, tv[i].res);
            if (i == 0) begin
                req_a[0 +: W] = tv[4].a; req_b[0 +: W] = tv[4].b;
                req_valid[0] = 1'b1;
            end
        end

        // unit_ready held low for 10 cycles with requester 1 pending.
        @(negedge clk);
        ready_en = 1'b0;
        req_a[1*W +: W] = ONE; req_b[1*W +: W] = ONE; req_valid = 4'b0010;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t3_hold_no_grant", {unit_valid, req_ready}, 0);
        end
        ready_en = 1'b1;
        @(negedge clk);
        chk("t3_grant_after_ready", {unit_valid, req_ready}, 64'h12);
        req_valid = '0;
        wait_finish(f, r);
        chk("t3_result", r, 64'h4000_0000_0000_0000);

        // Spurious unit_finish while idle.
        @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        chk("t4_no_finish", {busy, rsp_finish}, 0);
        @(negedge clk);
        chk("t4_still_idle", {busy, rsp_finish}, 0);

        // Reset while in WAIT; the unit's late finish must be dropped.
        lat = 8;
        req_a[3*W +: W] = TWO; req_b[3*W +: W] = TWO; req_valid = 4'b1000;
        wait_ready(id);
        chk("t5_grant3", 64'(id), 3);
        req_valid = '0;
        repeat (2) @(negedge clk);
        chk("t5_busy_wait", 64'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_hs", {unit_valid, busy, err_timeout, req_ready, rsp_finish}, 0);
        chk("t5_rst_result", rsp_result, 0);
        chk("t5_rst_unit_ab", unit_a | unit_b, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_unit_finish();
        @(negedge clk);
        chk("t5_late_finish_ignored", {busy, rsp_finish}, 0);
        lat = 5;
        req_a[0 +: W] = ONE; req_b[0 +: W] = TWO;
        req_a[3*W +: W] = TWO; req_b[3*W +: W] = TWO;
        req_valid = 4'b1001;
        wait_ready(id);
        chk("t5_grant0_after_reset", 64'(id), 0);
        req_valid[0] = 1'b0;
        wait_finish(f, r);
        chk("t5_finish0", {f, r}, {4'b0001, 64'h4008_0000_0000_0000});
        wait_ready(id);
        chk("t5_grant3_next", 64'(id), 3);
        req_valid[3] = 1'b0;
        wait_finish(f, r);
        chk("t5_finish3", {f, r}, {4'b1000, 64'h4010_0000_0000_0000});

        // Unit that never finishes.
        lat = 500;
        req_a[2*W +: W] = ONE; req_b[2*W +: W] = ONE; req_valid = 4'b0100;
        wait_ready(id);
        chk("t6_grant2", 64'(id), 2);
        req_valid = '0;
`ifdef FP_ARB_WDOG_EN
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            n++;
            if (rsp_finish != '0) break;
        end
        chk("t6_wdog_cycles", 64'(n), 17);
        chk("t6_err_timeout", 64'(err_timeout), 1);
        chk("t6_finish_owner", 64'(rsp_finish), 64'h4);
        chk("t6_qnan", rsp_result, 64'h7FF8_0000_0000_0000);
        @(negedge clk);
        chk("t6_back_idle", {busy, err_timeout, rsp_finish}, 0);
        model_clear = 1'b1;
        @(negedge clk);
        model_clear = 1'b0;
`else
        seen_bad = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (err_timeout || rsp_finish != '0) seen_bad = 1'b1;
        end
        chk("t6_no_timeout", 64'(seen_bad), 0);
        chk("t6_still_wait", 64'(busy), 1);
        model_clear = 1'b1;
        do_reset();
        model_clear = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
